// File: rtl/packet_axis_reader.sv
// Packet buffer to AXI-Stream reader: issues word reads for one packet slot,
// queues the returned words in a 3-entry FIFO and frees the slot with an ack pulse.
module packet_axis_reader #(
  parameter  int data_width_p  = 64,
  parameter  int els_p         = 2048,
  localparam int bytes_lp      = data_width_p/8,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int size_width_lp = $clog2(els_p+1),
  localparam int lg_bytes_lp   = $clog2(bytes_lp),
  localparam int rsz_width_lp  = $clog2(lg_bytes_lp+1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     packet_avail_i,
  input  logic [size_width_lp-1:0] packet_rsize_i,
  output logic                     packet_ack_o,
  output logic                     packet_rvalid_o,
  output logic [addr_width_lp-1:0] packet_raddr_o,
  output logic [rsz_width_lp-1:0]  packet_rdata_size_o,
  input  logic [data_width_p-1:0]  packet_rdata_i,
  output logic [data_width_p-1:0]  m_axis_tdata_o,
  output logic [bytes_lp-1:0]      m_axis_tkeep_o,
  output logic                     m_axis_tlast_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i
);

  typedef enum logic [1:0] {IDLE, READ, ACK} state_e;

  localparam logic [size_width_lp-1:0] els_size_lp = size_width_lp'(els_p);

  state_e                     r_state, w_state_nxt;
  logic [size_width_lp-1:0]   r_size;
  logic [size_width_lp-1:0]   r_widx;
  logic                       r_inflight;
  logic [bytes_lp-1:0]        r_if_keep;
  logic                       r_if_last;
  logic [1:0]                 r_wptr, r_rptr, r_count;
  logic [data_width_p-1:0]    r_mem_data [3];
  logic [bytes_lp-1:0]        r_mem_keep [3];
  logic                       r_mem_last [3];

  logic                       w_rd, w_ack, w_push, w_pop, w_valid;
  logic                       w_can_issue, w_is_last;
  logic [2:0]                 w_occ;
  logic [size_width_lp-1:0]   w_last_idx;
  logic [lg_bytes_lp-1:0]     w_rem;
  logic [bytes_lp:0]          w_one_hot;
  logic [bytes_lp-1:0]        w_last_keep;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads in flight count against FIFO space so a returning word always has a slot.
  assign w_occ       = 3'(r_count) + 3'(r_inflight);
  assign w_can_issue = w_occ < 3'd3;
  assign w_last_idx  = (r_size - size_width_lp'(1)) >> lg_bytes_lp;
  assign w_is_last   = (r_widx == w_last_idx);
  assign w_rem       = r_size[lg_bytes_lp-1:0];
  assign w_one_hot   = (bytes_lp+1)'(1) << w_rem;
  assign w_last_keep = (w_rem == '0) ? '1 : w_one_hot[bytes_lp-1:0] - bytes_lp'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      IDLE: if (packet_avail_i) w_state_nxt = (packet_rsize_i == '0) ? ACK : READ;
      READ: if (w_can_issue) begin
        w_rd = 1'b1;
        if (w_is_last) w_state_nxt = ACK;
      end
      ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_push = r_inflight;
  assign w_pop  = (r_count != 2'd0) && m_axis_tready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_size     <= '0;
      r_widx     <= '0;
      r_inflight <= 1'b0;
      r_if_keep  <= '0;
      r_if_last  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (r_state == IDLE && packet_avail_i) begin
        r_size <= packet_rsize_i;
        r_widx <= '0;
      end
      if (w_rd) r_widx <= r_widx + size_width_lp'(1);
      // Tag travels with the read so it lands alongside the returning word.
      r_inflight <= w_rd;
      r_if_keep  <= w_is_last ? w_last_keep : '1;
      r_if_last  <= w_is_last;
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= packet_rdata_i;
      r_mem_keep[r_wptr] <= r_if_keep;
      r_mem_last[r_wptr] <= r_if_last;
    end
  end

  // Outputs are forced low while reset is held, independent of registered state.
  assign w_valid             = (r_count != 2'd0) && !reset_i;
  assign packet_rvalid_o     = w_rd && !reset_i;
  assign packet_ack_o        = w_ack && !reset_i;
  assign packet_raddr_o      = reset_i ? '0 : addr_width_lp'(r_widx << lg_bytes_lp);
  assign packet_rdata_size_o = rsz_width_lp'(lg_bytes_lp);
  assign m_axis_tvalid_o     = w_valid;
  assign m_axis_tdata_o      = w_valid ? r_mem_data[r_rptr] : '0;
  assign m_axis_tkeep_o      = w_valid ? r_mem_keep[r_rptr] : '0;
  assign m_axis_tlast_o      = w_valid && r_mem_last[r_rptr];

  always_ff @(posedge clk_i) begin
    if (!reset_i && packet_avail_i) assert (packet_rsize_i <= els_size_lp);
  end

endmodule

// File: tb/tb_packet_axis_reader.sv
// Scoreboarded bench for packet_axis_reader: 64-bit and 32-bit instances,
// memory model returns address-tagged words one cycle after each read strobe.
module tb_packet_axis_reader;
  localparam int SW = 12;
  localparam int AW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, avail, ack, rvalid, tlast, tvalid, tready;
  logic [SW-1:0] rsize;
  logic [AW-1:0] raddr;
  logic [1:0]    rdsz;
  logic [63:0]   rdata, tdata;
  logic [7:0]    tkeep;

  logic          rst32, avail32, ack32, rvalid32, tlast32, tvalid32;
  logic [SW-1:0] rsize32;
  logic [AW-1:0] raddr32;
  logic [1:0]    rdsz32;
  logic [31:0]   rdata32, tdata32;
  logic [3:0]    tkeep32;

  packet_axis_reader #(.data_width_p(64)) u64 (
    .clk_i(clk), .reset_i(rst), .packet_avail_i(avail), .packet_rsize_i(rsize),
    .packet_ack_o(ack), .packet_rvalid_o(rvalid), .packet_raddr_o(raddr),
    .packet_rdata_size_o(rdsz), .packet_rdata_i(rdata), .m_axis_tdata_o(tdata),
    .m_axis_tkeep_o(tkeep), .m_axis_tlast_o(tlast), .m_axis_tvalid_o(tvalid),
    .m_axis_tready_i(tready));

  packet_axis_reader #(.data_width_p(32)) u32 (
    .clk_i(clk), .reset_i(rst32), .packet_avail_i(avail32), .packet_rsize_i(rsize32),
    .packet_ack_o(ack32), .packet_rvalid_o(rvalid32), .packet_raddr_o(raddr32),
    .packet_rdata_size_o(rdsz32), .packet_rdata_i(rdata32), .m_axis_tdata_o(tdata32),
    .m_axis_tkeep_o(tkeep32), .m_axis_tlast_o(tlast32), .m_axis_tvalid_o(tvalid32),
    .m_axis_tready_i(1'b1));

  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  beat_t q64[$], q32[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int acks = 0, reads = 0, pops = 0, acks32 = 0;
  int cur_idx = 0, pkts = 0, first_tv = -1, last_ack_cyc = 0;
  logic [7:0] seed = 8'h00, seed32 = 8'h00;
  logic tog = 1'b0;
  logic stall_prev = 1'b0;
  beat_t held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [7:0] s, input logic [AW-1:0] a);
    return {2{s, 8'hC3, 5'h00, a}};
  endfunction

  always @(posedge clk) cyc++;

  // Buffer model: read data is a function of packet seed and address.
  always @(posedge clk) begin
    if (rvalid)   rdata   <= pat(seed, raddr);
    if (rvalid32) rdata32 <= 32'(pat(seed32, raddr32));
  end

  initial forever begin
    @(posedge clk); #1;
    if (tog) tready = ~tready;
  end

  always @(negedge clk) begin
    beat_t e;
    if (ack) begin acks++; last_ack_cyc = cyc; end
    if (rvalid) begin
      reads++;
      if (raddr == '0) chk("pkt_start_after_ack", 64'(acks), 64'(cur_idx));
      chk("fifo_bound", 64'((reads - pops) <= 3), 64'd1);
    end
    if (stall_prev) begin
      chk("stall_valid", 64'(tvalid), 64'd1);
      chk("stall_data", tdata, held.d);
      chk("stall_keep", 64'(tkeep), 64'(held.k));
      chk("stall_last", 64'(tlast), 64'(held.l));
    end
    stall_prev = tvalid && !tready;
    held = '{tdata, tkeep, tlast};
    if (tvalid && first_tv < 0) first_tv = cyc;
    if (tvalid && tready) begin
      pops++;
      if (q64.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_beat64: got %0h expected none", tdata);
      end else begin
        e = q64.pop_front();
        chk("data64", tdata, e.d);
        chk("keep64", 64'(tkeep), 64'(e.k));
        chk("last64", 64'(tlast), 64'(e.l));
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (ack32) acks32++;
    if (tvalid32) begin
      if (q32.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_beat32: got %0h expected none", tdata32);
      end else begin
        e = q32.pop_front();
        chk("data32", 64'(tdata32), e.d);
        chk("keep32", 64'(tkeep32), 64'(e.k));
        chk("last32", 64'(tlast32), 64'(e.l));
      end
    end
  end

  task automatic send64(input int size, input logic [7:0] s, input int nb, input logic [7:0] lk);
    int t;
    for (int i = 0; i < nb; i++)
      q64.push_back('{pat(s, AW'(i*8)), (i == nb-1) ? lk : 8'hFF, i == nb-1});
    seed = s; cur_idx = pkts; avail = 1'b1; rsize = SW'(size);
    t = 0;
    do begin @(negedge clk); t++; end while (!ack && t < 100);
    if (!ack) chk("ack_timeout64", 64'(t), 64'd0);
    @(posedge clk); #1;
    avail = 1'b0; pkts++;
  endtask

  task automatic send32(input int size, input logic [7:0] s, input int nb, input logic [3:0] lk);
    int t;
    for (int i = 0; i < nb; i++)
      q32.push_back('{64'(32'(pat(s, AW'(i*4)))), (i == nb-1) ? {4'h0, lk} : 8'h0F, i == nb-1});
    seed32 = s; avail32 = 1'b1; rsize32 = SW'(size);
    t = 0;
    do begin @(negedge clk); t++; end while (!ack32 && t < 100);
    if (!ack32) chk("ack_timeout32", 64'(t), 64'd0);
    @(posedge clk); #1;
    avail32 = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((q64.size() != 0 || q32.size() != 0 || tvalid || tvalid32) && t < 300) begin
      @(negedge clk); t++;
    end
    if (t >= 300) chk({nm, "_drain_timeout"}, 64'(q64.size() + q32.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, a0, r0;
    rst = 1'b1; rst32 = 1'b1; avail = 1'b1; rsize = SW'(13); tready = 1'b1;
    avail32 = 1'b0; rsize32 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_tlast", 64'(tlast), 0);
    chk("rst_raddr", 64'(raddr), 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", 64'(tkeep), 0);
    chk("rst_tvalid32", 64'(tvalid32), 0);
    @(posedge clk); #1;
    avail = 1'b0; rst = 1'b0; rst32 = 1'b0;
    @(posedge clk); #1;
    chk("rdata_size64", 64'(rdsz), 64'd3);
    chk("rdata_size32", 64'(rdsz32), 64'd2);

    // size 13: FF, 1F; first beat 3 cycles after avail sampled
    a0 = acks; first_tv = -1; t0 = cyc;
    send64(13, 8'h11, 2, 8'h1F);
    drain("s13");
    chk("s13_acks", 64'(acks), 64'(a0 + 1));
    chk("s13_latency", 64'(first_tv - t0), 64'd3);

    // size 0: ack only, one cycle after sampling
    a0 = acks; r0 = reads; t0 = cyc;
    send64(0, 8'h22, 0, 8'h00);
    drain("s0");
    chk("s0_acks", 64'(acks), 64'(a0 + 1));
    chk("s0_reads", 64'(reads), 64'(r0));
    chk("s0_ack_latency", 64'(last_ack_cyc - t0), 64'd1);

    a0 = acks;
    send64(16, 8'h33, 2, 8'hFF);
    send64(1, 8'h44, 1, 8'h01);
    drain("s16_s1");
    chk("s16_s1_acks", 64'(acks), 64'(a0 + 2));

    // size 64 with tready toggling each cycle
    a0 = acks; tog = 1'b1;
    send64(64, 8'h55, 8, 8'hFF);
    drain("s64");
    tog = 1'b0;
    @(posedge clk); #1;
    tready = 1'b1;
    chk("s64_acks", 64'(acks), 64'(a0 + 1));

    // back-to-back 9 and 24
    a0 = acks;
    send64(9, 8'h66, 2, 8'h01);
    send64(24, 8'h77, 3, 8'hFF);
    drain("b2b");
    chk("b2b_acks", 64'(acks), 64'(a0 + 2));

    // 32-bit size 6: F then 3
    send32(6, 8'h88, 2, 4'h3);
    drain("w32");
    chk("w32_acks", 64'(acks32), 64'd1);

    // reset as the first beat is presented: no ack, nothing queued survives
    a0 = acks32; seed32 = 8'h99; avail32 = 1'b1; rsize32 = SW'(6);
    repeat (3) @(posedge clk);
    #1;
    avail32 = 1'b0; rst32 = 1'b1;
    @(negedge clk);
    chk("rst_mid_tvalid32", 64'(tvalid32), 0);
    chk("rst_mid_ack32", 64'(ack32), 0);
    @(posedge clk); #1;
    rst32 = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_tvalid32_after", 64'(tvalid32), 0);
    chk("rst_mid_no_ack", 64'(acks32), 64'(a0));
    @(posedge clk); #1;
    send32(6, 8'hAA, 2, 4'h3);
    drain("w32_post_rst");
    chk("w32_post_rst_acks", 64'(acks32), 64'(a0 + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
